// File: rtl/saida_display.sv
// saida_display: binary-to-BCD output port driving eight 7-segment digits
// with a one-entry pending buffer, overflow flag and leading-zero blanking.
module saida_display #(
  parameter bit ATIVO_BAIXO = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] dado,
  input  logic        escrita,
  output logic        pronto,
  output logic        ocupado,
  output logic [55:0] segmentos,
  output logic        estouro,
  output logic [31:0] valor_exibido
);

  typedef enum logic [1:0] {
    OCIOSO,
    CONVERTE,
    ATUALIZA
  } estado_t;

  localparam logic [6:0]  APAGADO = ATIVO_BAIXO ? 7'h7F : 7'h00;
  localparam logic [55:0] TUDO_APAGADO = {8{APAGADO}};

  estado_t     estado_q, estado_d;
  logic [31:0] bin_q, bin_d;
  logic [39:0] bcd_q, bcd_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] orig_q, orig_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_v_q, pend_v_d;
  logic [55:0] seg_q, seg_d;
  logic        est_q, est_d;
  logic [31:0] val_q, val_d;

  logic [39:0] bcd_aj;
  logic [55:0] seg_novo;
  logic        est_novo;
  logic [7:0]  visivel;
  logic        carrega;
  logic [31:0] fonte;

  function automatic logic [6:0] codifica(input logic [3:0] d);
    logic [6:0] p;
    unique case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = 7'b1111111;
    endcase
    return ATIVO_BAIXO ? p : ~p;
  endfunction

  always_comb begin
    for (int i = 0; i < 10; i++) begin
      bcd_aj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ?
        bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
  end

  // Overflow shows all eight digits; otherwise blank above the top nonzero one
  always_comb begin
    est_novo   = |bcd_q[39:32];
    visivel    = '0;
    visivel[7] = est_novo | (|bcd_q[31:28]);
    for (int i = 6; i >= 1; i--) begin
      visivel[i] = visivel[i+1] | (|bcd_q[4*i +: 4]);
    end
    visivel[0] = 1'b1;
    seg_novo   = '0;
    for (int i = 0; i < 8; i++) begin
      seg_novo[7*i +: 7] = visivel[i] ?
        codifica(bcd_q[4*i +: 4]) : APAGADO;
    end
  end

  always_comb begin
    estado_d = estado_q;
    bin_d    = bin_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    orig_d   = orig_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    seg_d    = seg_q;
    est_d    = est_q;
    val_d    = val_q;
    carrega  = 1'b0;
    fonte    = dado;
    unique case (estado_q)
      OCIOSO: begin
        carrega = escrita;
      end
      CONVERTE: begin
        {bcd_d, bin_d} = {bcd_aj, bin_q} << 1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) estado_d = ATUALIZA;
        if (escrita) begin
          pend_d   = dado;
          pend_v_d = 1'b1;
        end
      end
      ATUALIZA: begin
        seg_d = seg_novo;
        est_d = est_novo;
        val_d = orig_q;
        if (pend_v_q) begin
          carrega = 1'b1;
          fonte   = pend_q;
          if (escrita) pend_d = dado;
          else pend_v_d = 1'b0;
        end else if (escrita) begin
          carrega = 1'b1;
        end else begin
          estado_d = OCIOSO;
        end
      end
      default: estado_d = OCIOSO;
    endcase
    if (carrega) begin
      bin_d    = fonte;
      orig_d   = fonte;
      bcd_d    = '0;
      cnt_d    = '0;
      estado_d = CONVERTE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= OCIOSO;
      bin_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      orig_q   <= '0;
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      seg_q    <= TUDO_APAGADO;
      est_q    <= 1'b0;
      val_q    <= '0;
    end else begin
      estado_q <= estado_d;
      bin_q    <= bin_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      orig_q   <= orig_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      seg_q    <= seg_d;
      est_q    <= est_d;
      val_q    <= val_d;
    end
  end

  assign pronto        = !pend_v_q;
  assign ocupado       = (estado_q != OCIOSO) | pend_v_q;
  assign segmentos     = seg_q;
  assign estouro       = est_q;
  assign valor_exibido = val_q;

endmodule
